// File: rtl/joy_db9md_pkg.sv
// Shared definitions for the Mega Drive DB9 pad emulator: button bit map,
// select-phase encodings and the pin pattern driven in each phase.
package joy_db9md_pkg;

    localparam int TIMEOUT_DEFAULT = 64000;

    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_B     = 4;
    localparam int BTN_C     = 5;
    localparam int BTN_A     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_MODE  = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_Y     = 10;
    localparam int BTN_Z     = 11;

    typedef enum logic [2:0] {
        PH_H1 = 3'd0,
        PH_L1 = 3'd1,
        PH_H2 = 3'd2,
        PH_L2 = 3'd3,
        PH_H3 = 3'd4,
        PH_L3 = 3'd5,
        PH_H4 = 3'd6,
        PH_L4 = 3'd7
    } phase_e;

    // Active-low pin levels {pin9,pin6,pin4,pin3,pin2,pin1} for one phase.
    function automatic logic [5:0] pad_pattern(input logic [2:0] ph, input logic [11:0] btn);
        logic [11:0] nb;
        logic [5:0]  pins;
        nb   = ~btn;
        pins = 6'h3F;
        case (ph)
            PH_H1, PH_H2, PH_H3: pins = {nb[BTN_C], nb[BTN_B], nb[BTN_R], nb[BTN_L], nb[BTN_D], nb[BTN_U]};
            PH_L1, PH_L2:        pins = {nb[BTN_START], nb[BTN_A], 2'b00, nb[BTN_D], nb[BTN_U]};
            PH_L3:               pins = {nb[BTN_START], nb[BTN_A], 4'b0000};
            PH_H4:               pins = {nb[BTN_C], nb[BTN_B], nb[BTN_MODE], nb[BTN_X], nb[BTN_Y], nb[BTN_Z]};
            PH_L4:               pins = {nb[BTN_START], nb[BTN_A], 4'b1111};
            default:             pins = 6'h3F;
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/joy_db9md_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; resets to RESET_VAL.
module sync_ff #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] ff;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ff <= {DEPTH{RESET_VAL}};
        end else begin
            ff[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) ff[i] <= ff[i-1];
        end
    end

    assign q_o = ff[DEPTH-1];

endmodule

// File: rtl/joy_db9md_pad.sv
// Mega Drive 3/6-button pad emulator: tracks the host select line through the
// eight-phase read cycle and drives the matching DB9 pin levels.
module joy_db9md_pad
    import joy_db9md_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        select_i,
    input  logic        six_btn_i,
    input  logic [11:0] buttons_i,
    output logic [5:0]  pad_o,
    output logic [2:0]  phase_o
);

    localparam int            IW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

    logic          sel_s, sel_q, sel_edge, timeout;
    logic [2:0]    phase, phase_nxt, ph_eff;
    logic [IW-1:0] idle, idle_nxt;

    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .d_i      (select_i),
        .q_o      (sel_s)
    );

    // An edge always advances the phase, even in the cycle the timeout fires.
    always_comb begin
        sel_edge  = sel_s ^ sel_q;
        timeout   = (idle == IDLE_MAX);
        phase_nxt = phase;
        idle_nxt  = idle;
        if (sel_edge) begin
            phase_nxt = phase + 3'd1;
            idle_nxt  = '0;
        end else if (timeout) begin
            phase_nxt = sel_s ? PH_H1 : PH_L1;
        end else begin
            idle_nxt = idle + 1'b1;
        end
        ph_eff = six_btn_i ? phase_nxt : {2'b00, phase_nxt[0]};
    end

    // pad_o is built from the next phase so it lands together with phase_o.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sel_q <= 1'b1;
            phase <= PH_H1;
            idle  <= '0;
            pad_o <= 6'h3F;
        end else begin
            sel_q <= sel_s;
            phase <= phase_nxt;
            idle  <= idle_nxt;
            pad_o <= pad_pattern(ph_eff, buttons_i);
        end
    end

    assign phase_o = phase;

endmodule

// File: tb/tb_joy_db9md_pad.sv
// Randomized and directed bench for joy_db9md_pad against a behavioural pad model.
module tb_joy_db9md_pad;

    localparam int T = 40;
    localparam int S = 2;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        select_i;
    logic        six_btn_i;
    logic [11:0] buttons_i;
    logic [5:0]  pad_o;
    logic [2:0]  phase_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    joy_db9md_pad #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(S)) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .select_i (select_i),
        .six_btn_i(six_btn_i),
        .buttons_i(buttons_i),
        .pad_o    (pad_o),
        .phase_o  (phase_o)
    );

    // Behavioural model: select history as a delay line, phase as a plain count.
    int         m_hist[$];
    int         m_prev, m_phase, m_idle;
    logic [5:0] m_pad;

    function automatic logic [5:0] exp_pad(int ph, logic six, logic [11:0] b);
        int e;
        logic r, l, d, u, bb, c, a, st, md, x, y, z;
        {z, y, x, md, st, a, c, bb, u, d, l, r} = b;
        e = six ? ph : ph % 2;
        case (e)
            0, 2, 4: return ~{c, bb, r, l, d, u};
            1, 3:    return {~st, ~a, 2'b00, ~d, ~u};
            5:       return {~st, ~a, 4'b0000};
            6:       return ~{c, bb, md, x, y, z};
            default: return {~st, ~a, 4'b1111};
        endcase
    endfunction

    task automatic model_reset();
        m_hist = {};
        for (int i = 0; i < S; i++) m_hist.push_back(1);
        m_prev  = 1;
        m_phase = 0;
        m_idle  = 0;
        m_pad   = 6'h3F;
    endtask

    task automatic model_step();
        int ss;
        ss = m_hist[S-1];
        if (ss != m_prev) begin
            m_phase = (m_phase + 1) % 8;
            m_idle  = 0;
        end else if (m_idle == T) begin
            m_phase = ss ? 0 : 1;
        end else begin
            m_idle++;
        end
        m_prev = ss;
        m_hist.push_front(int'(select_i));
        void'(m_hist.pop_back());
        m_pad = exp_pad(m_phase, six_btn_i, buttons_i);
    endtask

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        chk("pad", int'(pad_o), int'(m_pad));
        chk("phase", int'(phase_o), m_phase);
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic tog();
        select_i = ~select_i;
    endtask

    // Called just after a tick: asserts reset between clock edges.
    task automatic do_reset();
        #2 reset_n_i = 1'b0;
        model_reset();
        #1;
        chk("rst_pad", int'(pad_o), 'h3F);
        chk("rst_phase", int'(phase_o), 0);
        #1 reset_n_i = 1'b1;
    endtask

    task automatic seq_check(logic six, logic [7:0][5:0] exp);
        six_btn_i = six;
        buttons_i = 12'h041;
        select_i  = 1'b1;
        do_reset();
        ticks(4);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("seq%0d_ph%0d", six, i), int'(pad_o), int'(exp[i]));
            tog();
            ticks(8);
        end
        chk("seq_wrap", int'(phase_o), 0);
    endtask

    initial begin
        reset_n_i = 1'b0;
        select_i  = 1'b1;
        six_btn_i = 1'b1;
        buttons_i = 12'h000;
        model_reset();
        #12;
        chk("init_pad", int'(pad_o), 'h3F);
        chk("init_phase", int'(phase_o), 0);
        #1 reset_n_i = 1'b1;
        ticks(3);

        // Full read cycle, 6-button then 3-button (no ID phase)
        seq_check(1'b1, {6'h2F, 6'h3F, 6'h20, 6'h37, 6'h23, 6'h37, 6'h23, 6'h37});
        seq_check(1'b0, {6'h23, 6'h37, 6'h23, 6'h37, 6'h23, 6'h37, 6'h23, 6'h37});

        // Select-to-pad latency and button-to-pad latency
        six_btn_i = 1'b1;
        buttons_i = 12'h041;
        do_reset();
        ticks(4);
        tog();
        ticks(2);
        chk("lat2", int'(pad_o), 'h37);
        tick();
        chk("lat3", int'(pad_o), 'h23);
        buttons_i = 12'h0C4;
        tick();
        chk("btn1", int'(pad_o), 'h01);
        buttons_i = 12'h041;
        tog();
        ticks(4);

        // Idle timeout restarts the sequence
        do_reset();
        ticks(4);
        tog(); ticks(8);
        tog(); ticks(8);
        ticks(T + 5);
        chk("tmo_phase", int'(phase_o), 0);
        tog(); ticks(4);
        chk("tmo_l1_phase", int'(phase_o), 1);
        chk("tmo_l1_pad", int'(pad_o), 'h23);
        tog(); ticks(4);

        // Edge lands on the exact timeout cycle at phase 4
        do_reset();
        ticks(4);
        repeat (3) begin tog(); ticks(8); end
        tog();
        ticks(T + 1);
        chk("pre_edge", int'(phase_o), 4);
        tog();
        ticks(3);
        chk("edgewin", int'(phase_o), 5);
        tog(); ticks(4);

        // Reset in phase 6, then restart from phase 0
        do_reset();
        ticks(4);
        repeat (6) begin tog(); ticks(8); end
        chk("ph6", int'(phase_o), 6);
        do_reset();
        ticks(4);
        tog(); ticks(4);
        chk("post_rst_phase", int'(phase_o), 1);
        chk("post_rst_pad", int'(pad_o), 'h23);

        // Randomized select timing, buttons, mode and occasional reset
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 30) buttons_i = 12'($urandom);
            if (r % 10 == 0) six_btn_i = ~six_btn_i;
            if (r == 77) do_reset();
            tog();
            if (r < 8) ticks(int'($urandom_range(T - 3, T + 6)));
            else       ticks(int'($urandom_range(1, 12)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
